if_fetch_ctrl: RTL and testbench
================================

// Module: if_fetch_ctrl
// PURPOSE
//  IF-stage fetch controller. Owns the PC and drives instruction-memory addressing.
//  Registers the returned instruction into the IF/ID latch and applies stalls and redirects.
//  Detects the HALT word and drains the pipeline before freezing.
//  Upstream: hazard unit, branch/jump resolution in ID/EX. Downstream: ID stage decode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  HALT_INSTR  32'hFFFF_FFFF  instruction word that starts halt sequence
//  DRAIN_CYC   4              cycles from HALT latched into IF/ID until o_halted=1 (1..15)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-high reset
//  i_enable         in   1   global run enable; 0 freezes all state
//  i_stall          in   1   hazard stall; hold PC and IF/ID
//  i_branch_taken   in   1   EX-resolved branch redirect
//  i_branch_target  in   32  branch destination
//  i_jump           in   1   ID-resolved jump redirect
//  i_jump_target    in   32  jump destination
//  i_imem_instr     in   32  instruction word from instruction memory (combinational read)
//  o_imem_addr      out  32  = current PC, combinational, to instruction memory addr
//  o_pc             out  32  PC of instruction held in IF/ID
//  o_pc_plus4       out  32  o_pc + 4, registered
//  o_instr          out  32  IF/ID instruction; 32'h0 when bubble
//  o_valid          out  1   IF/ID holds a real instruction
//  o_halted         out  1   drain complete, fetch frozen
// BEHAVIOUR
//  Reset (async): PC=RESET_PC; o_pc=0, o_pc_plus4=0, o_instr=0, o_valid=0, o_halted=0.
//    State=FETCH; drain counter=0.
//  Latency: instruction at PC appears on o_instr/o_valid one edge after PC is presented.
//  Advance condition adv = i_enable & ~i_stall & state==FETCH.
//  Next-PC priority, evaluated only when i_enable=1:
//    i_branch_taken > i_jump > i_stall hold > PC+4.
//    Redirect overrides i_stall. Target[1:0] forced to 2'b00.
//    PC+4 wraps mod 2^32 (0xFFFFFFFC -> 0x0).
//  IF/ID update, evaluated only when i_enable=1:
//    Redirect (branch or jump) -> load bubble (instr=0, valid=0); fetched word discarded.
//    Else if adv -> load {PC, PC+4, i_imem_instr, valid=1}.
//    Else (stall) -> hold.
//  i_enable=0: PC, IF/ID, state and counter all hold, including redirects.
//  FSM states:
//    FETCH: normal. If adv & no redirect & i_imem_instr==HALT_INSTR:
//      latch HALT (valid=1); PC still advances to PC+4; go DRAIN; cnt=DRAIN_CYC.
//    DRAIN: PC frozen. Each enabled cycle, IF/ID loads bubble; cnt decrements.
//      Stall does not pause the count.
//      i_branch_taken -> HALT was wrong-path: PC=target, go FETCH, cnt=0.
//      i_jump is ignored in DRAIN.
//      cnt reaches 1 -> go HALTED.
//    HALTED: o_halted=1; PC and IF/ID frozen; redirects ignored. Exit only by reset.
//  Reset mid-operation, any state, returns to FETCH with reset values.
// CONFIGURATION
//  STEP_MODE_EN defined:
//    Adds input i_step (1 bit, single-cycle pulse) from the debug unit.
//    In FETCH, adv additionally requires i_step=1, giving exactly one instruction per pulse.
//    Redirects still apply in any enabled cycle.
//    DRAIN counts only on i_step cycles.
//  STEP_MODE_EN undefined: no i_step port; advance every enabled, unstalled cycle.
// TESTING
//  Reset, instr mem words A,B,C at 0x0/0x4/0x8, enable=1 for 3 cycles
//    -> o_pc 0x0,0x4,0x8; o_instr A,B,C; o_valid=1.
//  Stall asserted 2 cycles at PC=0x8 -> o_imem_addr stays 0x8; IF/ID holds B.
//    Release -> C appears next edge.
//  i_stall=1, i_branch_taken=1, target 0x43, same cycle
//    -> next PC=0x40; o_valid=0; fetch from 0x40 follows.
//  i_branch_taken target 0x80 and i_jump target 0x20 same cycle
//    -> PC=0x80 (branch wins); one bubble.
//  HALT_INSTR at 0xC -> HALT latched valid; PC=0x10 frozen; 4 bubbles; o_halted=1;
//    a later branch redirect is ignored.
//  Branch redirect at 2nd DRAIN cycle -> back to FETCH at target, o_halted stays 0.
//  Async reset pulse while HALTED -> PC=RESET_PC; o_halted=0 before next clk edge.
//  STEP_MODE_EN: three i_step pulses spaced 5 cycles -> exactly three valid IF/ID loads.

Source files
------------

// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: bundle of the IF-stage control, redirect, instruction
// memory and IF/ID output signals used by if_fetch_ctrl.
// Optional feature macro: STEP_MODE_EN (adds the single-step strobe i_step).
// master modport: the fetch controller itself.
// slave modport : the surrounding pipeline / memory / debug environment.

interface if_fetch_ctrl_if;
    logic        i_enable;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_jump;
    logic [31:0] i_jump_target;
    logic [31:0] i_imem_instr;
`ifdef STEP_MODE_EN
    logic        i_step;
`endif
    logic [31:0] o_imem_addr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        o_halted;

`ifdef STEP_MODE_EN
    modport master (
        input  i_enable, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_imem_instr, i_step,
        output o_imem_addr, o_pc, o_pc_plus4, o_instr, o_valid, o_halted
    );
    modport slave (
        output i_enable, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_imem_instr, i_step,
        input  o_imem_addr, o_pc, o_pc_plus4, o_instr, o_valid, o_halted
    );
`else
    modport master (
        input  i_enable, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_imem_instr,
        output o_imem_addr, o_pc, o_pc_plus4, o_instr, o_valid, o_halted
    );
    modport slave (
        output i_enable, i_stall, i_branch_taken, i_branch_target,
               i_jump, i_jump_target, i_imem_instr,
        input  o_imem_addr, o_pc, o_pc_plus4, o_instr, o_valid, o_halted
    );
`endif
endinterface

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch controller. Owns the PC, addresses the
// instruction memory, fills the IF/ID latch, applies stalls and redirects,
// and drains the pipeline after a HALT word before freezing.
// Optional feature macro: STEP_MODE_EN (debug single-step: fetch advances
// and the drain counter decrements only on i_step pulses).

module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter int unsigned DRAIN_CYC  = 4
) (
    input  logic              clk,
    input  logic              reset,
    if_fetch_ctrl_if.master   bus
);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [1:0] ST_FETCH  = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC);

    // Redirect targets are word aligned: low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Sequential PC increment; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_incr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    logic [31:0] pc_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc4_r;
    logic [31:0] ifid_instr_r;
    logic        ifid_valid_r;
    logic        halted_r;
    logic [1:0]  state_r;
    logic [3:0]  cnt_r;

    logic [31:0] pc_n_s;
    logic [31:0] ifid_pc_n_s;
    logic [31:0] ifid_pc4_n_s;
    logic [31:0] ifid_instr_n_s;
    logic        ifid_valid_n_s;
    logic        halted_n_s;
    logic [1:0]  state_n_s;
    logic [3:0]  cnt_n_s;
    logic        step_ok_s;
    logic        adv_s;
    logic [31:0] pc_plus4_s;

`ifdef STEP_MODE_EN
    assign step_ok_s = bus.i_step;
`else
    assign step_ok_s = 1'b1;
`endif

    assign pc_plus4_s = pc_incr(pc_r);
    assign adv_s      = bus.i_enable & ~bus.i_stall & step_ok_s & (state_r == ST_FETCH);

    // Next-state logic for PC, IF/ID latch, FSM state and drain counter.
    always_comb begin
        pc_n_s         = pc_r;
        ifid_pc_n_s    = ifid_pc_r;
        ifid_pc4_n_s   = ifid_pc4_r;
        ifid_instr_n_s = ifid_instr_r;
        ifid_valid_n_s = ifid_valid_r;
        halted_n_s     = halted_r;
        state_n_s      = state_r;
        cnt_n_s        = cnt_r;

        if (bus.i_enable) begin
            case (state_r)
                ST_FETCH: begin
                    if (bus.i_branch_taken) begin
                        // Branch wins over jump and over a hazard stall.
                        pc_n_s         = align_word(bus.i_branch_target);
                        ifid_instr_n_s = 32'h0000_0000;
                        ifid_valid_n_s = 1'b0;
                    end else if (bus.i_jump) begin
                        pc_n_s         = align_word(bus.i_jump_target);
                        ifid_instr_n_s = 32'h0000_0000;
                        ifid_valid_n_s = 1'b0;
                    end else if (adv_s) begin
                        pc_n_s         = pc_plus4_s;
                        ifid_pc_n_s    = pc_r;
                        ifid_pc4_n_s   = pc_plus4_s;
                        ifid_instr_n_s = bus.i_imem_instr;
                        ifid_valid_n_s = 1'b1;
                        if (bus.i_imem_instr == HALT_INSTR) begin
                            // HALT itself is passed on as a valid instruction.
                            state_n_s = ST_DRAIN;
                            cnt_n_s   = DRAIN_LOAD;
                        end else begin
                            state_n_s = ST_FETCH;
                        end
                    end else begin
                        // Stalled (or waiting for a step pulse): hold everything.
                        pc_n_s = pc_r;
                    end
                end

                ST_DRAIN: begin
                    if (bus.i_branch_taken) begin
                        // HALT was fetched on a wrong path: resume at the target.
                        pc_n_s         = align_word(bus.i_branch_target);
                        ifid_instr_n_s = 32'h0000_0000;
                        ifid_valid_n_s = 1'b0;
                        state_n_s      = ST_FETCH;
                        cnt_n_s        = 4'd0;
                    end else if (step_ok_s) begin
                        // Jumps and stalls do not affect the drain sequence.
                        ifid_instr_n_s = 32'h0000_0000;
                        ifid_valid_n_s = 1'b0;
                        if (cnt_r <= 4'd1) begin
                            state_n_s  = ST_HALTED;
                            cnt_n_s    = 4'd0;
                            halted_n_s = 1'b1;
                        end else begin
                            cnt_n_s = cnt_r - 4'd1;
                        end
                    end else begin
                        cnt_n_s = cnt_r;
                    end
                end

                ST_HALTED: begin
                    // Frozen until reset; redirects are ignored.
                    halted_n_s = 1'b1;
                end

                default: begin
                    // Unreachable encoding: recover to a clean fetch state.
                    state_n_s      = ST_FETCH;
                    cnt_n_s        = 4'd0;
                    ifid_instr_n_s = 32'h0000_0000;
                    ifid_valid_n_s = 1'b0;
                    halted_n_s     = 1'b0;
                end
            endcase
        end else begin
            // Global enable low: all state holds, redirects included.
            state_n_s = state_r;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_instr_r <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            halted_r     <= 1'b0;
            state_r      <= ST_FETCH;
            cnt_r        <= 4'd0;
        end else begin
            pc_r         <= pc_n_s;
            ifid_pc_r    <= ifid_pc_n_s;
            ifid_pc4_r   <= ifid_pc4_n_s;
            ifid_instr_r <= ifid_instr_n_s;
            ifid_valid_r <= ifid_valid_n_s;
            halted_r     <= halted_n_s;
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
        end
    end

    assign bus.o_imem_addr = pc_r;
    assign bus.o_pc        = ifid_pc_r;
    assign bus.o_pc_plus4  = ifid_pc4_r;
    assign bus.o_instr     = ifid_instr_r;
    assign bus.o_valid     = ifid_valid_r;
    assign bus.o_halted    = halted_r;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed self-checking bench for if_fetch_ctrl.
// Instruction memory is modelled as a word array read combinationally.

module tb_if_fetch_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] mem [0:255];

    if_fetch_ctrl_if bus();

    if_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .HALT_INSTR (32'hFFFF_FFFF),
        .DRAIN_CYC  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.i_imem_instr = mem[bus.o_imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_stall         = 1'b0;
        bus.i_branch_taken  = 1'b0;
        bus.i_branch_target = 32'h0000_0000;
        bus.i_jump          = 1'b0;
        bus.i_jump_target   = 32'h0000_0000;
`ifdef STEP_MODE_EN
        bus.i_step          = 1'b0;
`endif
    endtask

    task automatic apply_reset();
        bus.i_enable = 1'b0;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.o_imem_addr, bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_valid, bus.o_halted}
            !== {32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: addr=%h pc=%h pc4=%h instr=%h valid=%b halted=%b expected all zero",
                     bus.o_imem_addr, bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_valid, bus.o_halted);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_fetch_and_stall();
        bus.i_enable = 1'b1;
        tick();
        checks++;
        if ({bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_valid, bus.o_imem_addr}
            !== {32'h0, 32'h4, 32'hA000_0000, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL fetch_A: pc=%h pc4=%h instr=%h valid=%b addr=%h expected 0/4/a0000000/1/4",
                     bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_valid, bus.o_imem_addr);
        end
        tick();
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr}
            !== {32'h4, 32'hA000_0001, 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL fetch_B: pc=%h instr=%h valid=%b addr=%h expected 4/a0000001/1/8",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr);
        end
        bus.i_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.o_imem_addr, bus.o_pc, bus.o_instr, bus.o_valid}
                !== {32'h8, 32'h4, 32'hA000_0001, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold%0d: addr=%h pc=%h instr=%h valid=%b expected 8/4/a0000001/1",
                         i, bus.o_imem_addr, bus.o_pc, bus.o_instr, bus.o_valid);
            end
        end
        bus.i_stall = 1'b0;
        tick();
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr}
            !== {32'h8, 32'hA000_0002, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL fetch_C: pc=%h instr=%h valid=%b addr=%h expected 8/a0000002/1/c",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr);
        end
    endtask

    task automatic test_redirects();
        // Branch overrides stall; target is word aligned.
        bus.i_stall         = 1'b1;
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h0000_0043;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_instr, bus.o_valid} !== {32'h40, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL stall_branch: addr=%h instr=%h valid=%b expected 40/0/0",
                     bus.o_imem_addr, bus.o_instr, bus.o_valid);
        end
        clear_inputs();
        tick();
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr}
            !== {32'h40, 32'hA000_0010, 1'b1, 32'h44}) begin
            errors++;
            $display("FAIL branch_fetch: pc=%h instr=%h valid=%b addr=%h expected 40/a0000010/1/44",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr);
        end
        // Branch beats jump in the same cycle.
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h0000_0080;
        bus.i_jump          = 1'b1;
        bus.i_jump_target   = 32'h0000_0020;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_valid} !== {32'h80, 1'b0}) begin
            errors++;
            $display("FAIL branch_vs_jump: addr=%h valid=%b expected 80/0", bus.o_imem_addr, bus.o_valid);
        end
        clear_inputs();
        tick();
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr}
            !== {32'h80, 32'hA000_0020, 1'b1, 32'h84}) begin
            errors++;
            $display("FAIL after_branch: pc=%h instr=%h valid=%b addr=%h expected 80/a0000020/1/84",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr);
        end
        // Jump alone redirects with one bubble.
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'h0000_0032;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_valid} !== {32'h30, 1'b0}) begin
            errors++;
            $display("FAIL jump_only: addr=%h valid=%b expected 30/0", bus.o_imem_addr, bus.o_valid);
        end
        clear_inputs();
        tick();
        // Enable low freezes everything, even a branch.
        bus.i_enable        = 1'b0;
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h0000_0040;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_pc, bus.o_instr, bus.o_valid}
            !== {32'h34, 32'h30, 32'hA000_000C, 1'b1}) begin
            errors++;
            $display("FAIL enable_hold: addr=%h pc=%h instr=%h valid=%b expected 34/30/a000000c/1",
                     bus.o_imem_addr, bus.o_pc, bus.o_instr, bus.o_valid);
        end
        bus.i_enable = 1'b1;
        clear_inputs();
    endtask

    task automatic test_wrap();
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        tick();
        checks++;
        if ({bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_imem_addr}
            !== {32'hFFFF_FFFC, 32'h0, 32'hA000_00FF, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h pc4=%h instr=%h addr=%h expected fffffffc/0/a00000ff/0",
                     bus.o_pc, bus.o_pc_plus4, bus.o_instr, bus.o_imem_addr);
        end
    endtask

    task automatic test_halt();
        mem[3] = 32'hFFFF_FFFF;
        apply_reset();
        bus.i_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr, bus.o_halted}
            !== {32'hC, 32'hFFFF_FFFF, 1'b1, 32'h10, 1'b0}) begin
            errors++;
            $display("FAIL halt_latched: pc=%h instr=%h valid=%b addr=%h halted=%b expected c/ffffffff/1/10/0",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr, bus.o_halted);
        end
        for (int i = 0; i < 4; i++) begin
            bus.i_stall = (i == 1) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if ({bus.o_valid, bus.o_instr, bus.o_imem_addr, bus.o_halted}
                !== {1'b0, 32'h0, 32'h10, (i == 3) ? 1'b1 : 1'b0}) begin
                errors++;
                $display("FAIL drain%0d: valid=%b instr=%h addr=%h halted=%b expected 0/0/10/%0d",
                         i, bus.o_valid, bus.o_instr, bus.o_imem_addr, bus.o_halted, (i == 3) ? 1 : 0);
            end
        end
        clear_inputs();
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h0000_0040;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_halted, bus.o_valid} !== {32'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halted_ignores_branch: addr=%h halted=%b valid=%b expected 10/1/0",
                     bus.o_imem_addr, bus.o_halted, bus.o_valid);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.o_imem_addr, bus.o_halted, bus.o_valid} !== {32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: addr=%h halted=%b valid=%b expected 0/0/0",
                     bus.o_imem_addr, bus.o_halted, bus.o_valid);
        end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_drain_redirect();
        apply_reset();
        bus.i_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        // Jump in DRAIN is ignored.
        bus.i_jump        = 1'b1;
        bus.i_jump_target = 32'h0000_0020;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_valid, bus.o_halted} !== {32'h10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_jump_ignored: addr=%h valid=%b halted=%b expected 10/0/0",
                     bus.o_imem_addr, bus.o_valid, bus.o_halted);
        end
        clear_inputs();
        bus.i_branch_taken  = 1'b1;
        bus.i_branch_target = 32'h0000_0040;
        tick();
        checks++;
        if ({bus.o_imem_addr, bus.o_valid, bus.o_halted} !== {32'h40, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_branch: addr=%h valid=%b halted=%b expected 40/0/0",
                     bus.o_imem_addr, bus.o_valid, bus.o_halted);
        end
        clear_inputs();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_halted}
            !== {32'h50, 32'hA000_0014, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL resume_after_drain: pc=%h instr=%h valid=%b halted=%b expected 50/a0000014/1/0",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_halted);
        end
    endtask

`ifdef STEP_MODE_EN
    task automatic test_step();
        apply_reset();
        bus.i_enable = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus.i_step = ((c % 5) == 0) ? 1'b1 : 1'b0;
            tick();
            if (c == 2) begin
                checks++;
                if ({bus.o_pc, bus.o_imem_addr, bus.o_valid} !== {32'h0, 32'h4, 1'b1}) begin
                    errors++;
                    $display("FAIL step_gap: pc=%h addr=%h valid=%b expected 0/4/1",
                             bus.o_pc, bus.o_imem_addr, bus.o_valid);
                end
            end
        end
        bus.i_step = 1'b0;
        checks++;
        if ({bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr}
            !== {32'h8, 32'hA000_0002, 1'b1, 32'hC}) begin
            errors++;
            $display("FAIL step_three: pc=%h instr=%h valid=%b addr=%h expected 8/a0000002/1/c",
                     bus.o_pc, bus.o_instr, bus.o_valid, bus.o_imem_addr);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        bus.i_enable = 1'b0;
        clear_inputs();
        test_reset();
        test_fetch_and_stall();
        test_redirects();
        test_wrap();
        test_halt();
        test_async_reset();
        test_drain_redirect();
`ifdef STEP_MODE_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
